// File: rtl/sb_tx_serializer.sv
// sb_tx_serializer: sideband TX serializer. Shifts PKT_W-bit packets out LSB
// first, one UI per i_clk, with a forwarded-clock enable, and enforces
// GAP_W idle UIs between packets. o_ser_done pulses on the last UI.
// Build option: define SB_SER_BUF_EN for a one-entry holding buffer.
module sb_tx_serializer #(
  parameter int PKT_W = 64,
  parameter int GAP_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data_valid,
  input  logic [PKT_W-1:0] i_data,
  output logic             o_ready,
  output logic             o_txdata_sb,
  output logic             o_txclk_en,
  output logic             o_ser_done,
  output logic             o_busy
);

  localparam int CNT_W  = $clog2(PKT_W);
  localparam int GAP_CW = $clog2(GAP_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PKT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(PKT_W - 2);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_CW-1:0]  gap_q, gap_d;
  logic               txdata_q, txdata_d;
  logic               txclk_en_q, txclk_en_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               accept;
  logic               load;
  logic [PKT_W-1:0]   load_data;
`ifdef SB_SER_BUF_EN
  logic [PKT_W-1:0]   buf_q, buf_d;
  logic               buf_vld_q, buf_vld_d;
`endif

  assign accept      = i_data_valid & ready_q;
  assign o_ready     = ready_q;
  assign o_txdata_sb = txdata_q;
  assign o_txclk_en  = txclk_en_q;
  assign o_ser_done  = done_q;
  assign o_busy      = busy_q;

  // Next-state logic. All outputs are registered, so each output flop is
  // loaded with the value belonging to the UI that follows this edge:
  // shift_q always holds the bits still to be sent after the one on the lane.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    txdata_d   = 1'b0;
    txclk_en_d = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    load_data  = '0;
`ifdef SB_SER_BUF_EN
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_data = i_data;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          gap_d   = '0;
          shift_d = '0;
        end else begin
          txdata_d   = shift_q[0];
          txclk_en_d = 1'b1;
          shift_d    = shift_q >> 1;
          cnt_d      = cnt_q + 1'b1;
          done_d     = (cnt_q == CNT_PRE);
        end
`ifdef SB_SER_BUF_EN
        if (accept) begin
          buf_d     = i_data;
          buf_vld_d = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
`ifdef SB_SER_BUF_EN
          if (buf_vld_q) begin
            load      = 1'b1;
            load_data = buf_q;
            buf_vld_d = accept;
            if (accept) buf_d = i_data;
          end else if (accept) begin
            load      = 1'b1;
            load_data = i_data;
          end
`else
          if (accept) begin
            load      = 1'b1;
            load_data = i_data;
          end
`endif
          if (!load) state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
`ifdef SB_SER_BUF_EN
          if (accept) begin
            buf_d     = i_data;
            buf_vld_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = SHIFT;
      shift_d    = load_data >> 1;
      txdata_d   = load_data[0];
      txclk_en_d = 1'b1;
      cnt_d      = '0;
    end

`ifdef SB_SER_BUF_EN
    ready_d = !buf_vld_d;
    busy_d  = (state_d != IDLE) || buf_vld_d;
`else
    ready_d = (state_d == IDLE) || ((state_d == GAP) && (gap_d == GAP_LAST));
    busy_d  = (state_d != IDLE);
`endif
  end

  // State, datapath and registered outputs; reset discards any packet in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      txdata_q   <= 1'b0;
      txclk_en_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      txdata_q   <= txdata_d;
      txclk_en_q <= txclk_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

`ifdef SB_SER_BUF_EN
  // Holding buffer for a packet accepted while the lane is busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Testbench for sb_tx_serializer. Stimulus predicts, from packet-level timing
// rules, when each packet is accepted and when its first UI appears, and
// queues it; a negedge monitor checks the lane against the queue.
module tb_sb_tx_serializer;

  localparam int PKT_W = 64;
  localparam int GAP_W = 32;
  localparam int SPAN  = PKT_W + GAP_W;
`ifdef SB_SER_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_data_valid = 1'b0;
  logic [PKT_W-1:0] i_data = '0;
  logic             o_ready, o_txdata_sb, o_txclk_en, o_ser_done, o_busy;

  sb_tx_serializer #(.PKT_W(PKT_W), .GAP_W(GAP_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_txdata_sb  (o_txdata_sb),
    .o_txclk_en   (o_txclk_en),
    .o_ser_done   (o_ser_done),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [PKT_W-1:0] d; int s; } pkt_t;
  typedef struct { int a; int s; } rec_t;

  pkt_t expq[$];
  rec_t recs[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   next_acc = 0;
  int   last_s = -1000;
  int   bit_idx = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: lane contents, done pulse, start time and busy against the model.
  always @(negedge i_clk) begin
    logic busy_exp;
    if (!i_rst_n) begin
      bit_idx = 0;
    end else begin
      busy_exp = 1'b0;
      foreach (recs[i])
        if (recs[i].a < cyc && cyc <= recs[i].s + SPAN - 1) busy_exp = 1'b1;
      chk_bit("busy", o_busy, busy_exp);
      if (o_txclk_en) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_tx cyc=%0d got=txclk_en expected=no packet", cyc);
        end else begin
          if (bit_idx == 0) chk_int("start_cycle", cyc, expq[0].s);
          chk_bit("txdata", o_txdata_sb, expq[0].d[bit_idx]);
          chk_bit("ser_done", o_ser_done, bit_idx == PKT_W - 1);
          bit_idx++;
          if (bit_idx == PKT_W) begin
            void'(expq.pop_front());
            bit_idx = 0;
          end
        end
      end else begin
        chk_bit("idle_txdata", o_txdata_sb, 1'b0);
        chk_bit("idle_done", o_ser_done, 1'b0);
        chk_int("packet_complete", bit_idx, 0);
      end
    end
  end

  task automatic chk_all_zero(input string pfx);
    chk_bit({pfx, "_txdata"}, o_txdata_sb, 1'b0);
    chk_bit({pfx, "_txclk_en"}, o_txclk_en, 1'b0);
    chk_bit({pfx, "_done"}, o_ser_done, 1'b0);
    chk_bit({pfx, "_busy"}, o_busy, 1'b0);
    chk_bit({pfx, "_ready"}, o_ready, 1'b0);
  endtask

  // Holds reset over three edges, releases it mid-cycle; ends at posedge+1.
  task automatic release_reset();
    repeat (3) @(posedge i_clk);
    #1 chk_all_zero("rst");
    #1 i_rst_n = 1'b1;
    next_acc = cyc + 1;
    last_s = -1000;
    chk_bit("ready_at_release", o_ready, 1'b0);
    @(posedge i_clk); #1;
    chk_bit("ready_after_release", o_ready, 1'b1);
  endtask

  // Offer packet d after idle_cycles; predicts acceptance cycle a and start s.
  // Entered and left at 1 time unit after a rising edge.
  task automatic send(input logic [PKT_W-1:0] d, input int unsigned idle_cycles);
    int o, a, s;
    logic [PKT_W-1:0] junk;
    i_data_valid = 1'b0;
    repeat (idle_cycles) begin @(posedge i_clk); #1; end
    o = cyc;
    a = (o > next_acc) ? o : next_acc;
    s = (a + 1 > last_s + SPAN) ? a + 1 : last_s + SPAN;
    expq.push_back('{d: d, s: s});
    recs.push_back('{a: a, s: s});
    last_s = s;
    next_acc = BUF ? s : s + SPAN - 1;
    i_data_valid = 1'b1;
    for (int c = o; c <= a; c++) begin
      junk = {$urandom, $urandom};
      i_data = (c == a) ? d : junk;
      chk_bit("ready", o_ready, c == a);
      @(posedge i_clk); #1;
    end
    i_data_valid = 1'b0;
  endtask

  initial begin
    logic [PKT_W-1:0] p;
    int unsigned sel, gap;
    release_reset();

    // Single packet from idle.
    send(64'hA5A5_0000_FFFF_1234, 2);
    // Two packets, valid held continuously.
    send({$urandom, $urandom}, 120);
    send({$urandom, $urandom}, 0);
    // All-ones then all-zeros back to back.
    send('1, 120);
    send('0, 0);
    // Offer during SHIFT.
    send({$urandom, $urandom}, 120);
    send({$urandom, $urandom}, 10);
    // Three back-to-back offers.
    send({$urandom, $urandom}, 120);
    send({$urandom, $urandom}, 0);
    send({$urandom, $urandom}, 0);

    // Reset at UI 30 of a packet.
    send({$urandom, $urandom}, 320);
    while (cyc < last_s + 30) begin @(posedge i_clk); #1; end
    #1 i_rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    expq.delete();
    recs.delete();
    release_reset();
    send(64'h1, 0);

    // Randomized traffic with mixed spacing.
    for (int unsigned i = 0; i < 14; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      gap = $urandom_range(0, 2);
      else if (sel < 8) gap = $urandom_range(30, 90);
      else              gap = $urandom_range(97, 130);
      p = {$urandom, $urandom};
      send(p, gap);
    end

    while (cyc <= last_s + SPAN + 4) begin @(posedge i_clk); #1; end
    chk_int("all_packets_sent", expq.size(), 0);
    chk_bit("final_busy", o_busy, 1'b0);
    chk_bit("final_ready", o_ready, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog cyc=%0d got=timeout expected=completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
